// File: rtl/apb_master_arb.sv
// -----------------------------------------------------------------------------
// apb_master_arb
// Two-requester APB master. Arbitrates round-robin between two local
// requesters and runs one SETUP/ACCESS transfer at a time on a zero-wait APB
// slave. The slave has no pready and registers prdata on the ACCESS edge, so
// reads add one RDWAIT cycle before the data is captured.
//
// Ports
//   clk                  clock, rising edge
//   reset                asynchronous active-low reset
//   req0/req1            level request, held until the matching ack
//   wr0/wr1              1 = write, 0 = read
//   addr0/addr1          target register address
//   wdata0/wdata1        write data
//   ack0/ack1            one-cycle completion pulse to the owning requester
//   rdata                read data, valid in the ack cycle of a read
//   busy                 high whenever the FSM is not idle
//   paddr/pwdata/pwrite  APB address, write data, direction
//   psel/penable         APB select / enable
//   prdata               APB read data (top bit ignored)
// -----------------------------------------------------------------------------
module apb_master_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W:0]   prdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_RDWAIT = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;

  // grant_q is both the round-robin history and the owner of the transfer in
  // flight: it is only updated on the IDLE edge that accepts a request.
  logic                grant_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                pwrite_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                win_s;
  logic                psel_s;
  logic                penable_s;
  logic                ack0_s;
  logic                ack1_s;
  logic                busy_s;

  // The slave drives a spare top bit that carries no data.
  logic                unused_prdata_s;
  assign unused_prdata_s = prdata[DATA_W];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (pwrite_q) begin
          state_d = S_RESP;
        end else begin
          state_d = S_RDWAIT;
        end
      end
      S_RDWAIT: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Round-robin winner; under contention the side that did not win last time goes.
  always_comb begin
    win_s = 1'b0;
    if (req0 && req1) begin
      win_s = ~grant_q;
    end else if (req0) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
  end

  // Transfer latch (held until the next grant) and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q  <= 1'b1;
      paddr_q  <= {ADDR_W{1'b0}};
      pwdata_q <= {DATA_W{1'b0}};
      pwrite_q <= 1'b0;
      rdata_q  <= {DATA_W{1'b0}};
    end else begin
      if ((state_q == S_IDLE) && (req0 || req1)) begin
        grant_q  <= win_s;
        paddr_q  <= win_s ? addr1  : addr0;
        pwdata_q <= win_s ? wdata1 : wdata0;
        pwrite_q <= win_s ? wr1    : wr0;
      end
      // prdata was registered by the slave on the ACCESS edge, so it is
      // stable throughout RDWAIT.
      if (state_q == S_RDWAIT) begin
        rdata_q <= prdata[DATA_W-1:0];
      end
    end
  end

  // Output decode from state (plus the registered owner for the ack).
  always_comb begin
    psel_s    = 1'b0;
    penable_s = 1'b0;
    ack0_s    = 1'b0;
    ack1_s    = 1'b0;
    busy_s    = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy_s = 1'b0;
      end
      S_SETUP: begin
        psel_s = 1'b1;
      end
      S_ACCESS: begin
        psel_s    = 1'b1;
        penable_s = 1'b1;
      end
      S_RDWAIT: begin
        psel_s = 1'b0;
      end
      S_RESP: begin
        ack0_s = ~grant_q;
        ack1_s = grant_q;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign psel    = psel_s;
  assign penable = penable_s;
  assign ack0    = ack0_s;
  assign ack1    = ack1_s;
  assign busy    = busy_s;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign pwrite  = pwrite_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arb
// Directed bench for apb_master_arb with a small zero-wait APB register
// slave model (0 start, 1 reset, 2 it_enable, 3 per_addr, 4 per_data).
// -----------------------------------------------------------------------------
module tb_apb_master_arb;

  logic       clk;
  logic       reset;
  logic       slv_rst_n;
  logic       req0, req1, wr0, wr1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1, busy, pwrite, psel, penable;
  logic [7:0] rdata, paddr, pwdata;
  logic [8:0] prdata;

  logic [7:0] sregs [0:7];

  int n_checks;
  int n_errors;
  int n_ack0;
  int n_ack1;
  logic both_ack;

  apb_master_arb #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .wr0     (wr0),
    .wr1     (wr1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .ack0    (ack0),
    .ack1    (ack1),
    .rdata   (rdata),
    .busy    (busy),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pwrite  (pwrite),
    .psel    (psel),
    .penable (penable),
    .prdata  (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: writes and read-data registration both happen on the ACCESS edge.
  // The spare top bit of prdata is driven high so it must be dropped by the master.
  always @(posedge clk or negedge slv_rst_n) begin
    if (!slv_rst_n) begin
      for (int i = 0; i < 8; i++) sregs[i] <= 8'h00;
      prdata <= 9'h000;
    end else if (psel && penable) begin
      if (pwrite) sregs[paddr[2:0]] <= pwdata;
      else        prdata <= {1'b1, sregs[paddr[2:0]]};
    end
  end

  // Ack pulse monitor.
  always @(negedge clk) begin
    if (ack0) n_ack0 = n_ack0 + 1;
    if (ack1) n_ack1 = n_ack1 + 1;
    if (ack0 && ack1) both_ack = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction from requester 'who'; starts at a negedge and returns at
  // the negedge where the ack is seen, with the request already dropped.
  task automatic run_txn(input int who, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wd, input int exp_lat,
                         input logic chk_rd, input logic [7:0] exp_rd);
    int   cyc;
    logic got;
    if (who == 0) begin
      req0 = 1'b1; wr0 = wr; addr0 = addr; wdata0 = wd;
    end else begin
      req1 = 1'b1; wr1 = wr; addr1 = addr; wdata1 = wd;
    end
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc = cyc + 1;
      if (cyc == 1) begin
        check("setup_psel",    {31'd0, psel},    32'd1);
        check("setup_penable", {31'd0, penable}, 32'd0);
        check("setup_paddr",   {24'd0, paddr},   {24'd0, addr});
        check("setup_pwrite",  {31'd0, pwrite},  {31'd0, wr});
        check("setup_busy",    {31'd0, busy},    32'd1);
        if (wr) check("setup_pwdata", {24'd0, pwdata}, {24'd0, wd});
      end
      if (cyc == 2) begin
        check("access_psel",    {31'd0, psel},    32'd1);
        check("access_penable", {31'd0, penable}, 32'd1);
        check("access_pwrite",  {31'd0, pwrite},  {31'd0, wr});
      end
      if ((who == 0 && ack0) || (who == 1 && ack1)) got = 1'b1;
    end
    check("ack_latency", cyc, exp_lat);
    if (chk_rd) check("rdata", {24'd0, rdata}, {24'd0, exp_rd});
    if (who == 0) req0 = 1'b0;
    else          req1 = 1'b0;
  endtask

  initial begin
    int   cyc;
    int   acks_before;
    logic got;

    n_checks = 0; n_errors = 0; n_ack0 = 0; n_ack1 = 0; both_ack = 1'b0;
    reset = 1'b0; slv_rst_n = 1'b0;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h00; wdata0 = 8'h01;
    req1 = 1'b0; wr1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;

    // Reset held 3 cycles with req0 high.
    repeat (3) @(negedge clk);
    slv_rst_n = 1'b1;
    check("rst_psel",    {31'd0, psel},    32'd0);
    check("rst_penable", {31'd0, penable}, 32'd0);
    check("rst_ack0",    {31'd0, ack0},    32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_paddr",   {24'd0, paddr},   32'd0);
    check("rst_rdata",   {24'd0, rdata},   32'd0);

    // Release: req0 (write addr 0 = 1) granted on the next edge.
    reset = 1'b1;
    run_txn(0, 1'b1, 8'h00, 8'h01, 3, 1'b0, 8'h00);
    @(negedge clk);
    check("startbit", {31'd0, sregs[0][0]}, 32'd1);
    check("idle_psel", {31'd0, psel}, 32'd0);

    // Write then read back per_addr.
    run_txn(0, 1'b1, 8'h03, 8'h5A, 3, 1'b0, 8'h00);
    @(negedge clk);
    run_txn(0, 1'b0, 8'h03, 8'h00, 4, 1'b1, 8'h5A);
    @(negedge clk);

    // Preload per_data; rdata must be unaffected by a write.
    run_txn(0, 1'b1, 8'h04, 8'hC3, 3, 1'b1, 8'h5A);
    @(negedge clk);

    // Back-to-back reads from requester 1.
    run_txn(1, 1'b0, 8'h04, 8'h00, 4, 1'b1, 8'hC3);
    @(negedge clk);
    check("b2b_idle_psel",  {31'd0, psel},  32'd0);
    check("b2b_idle_busy",  {31'd0, busy},  32'd0);
    check("b2b_held_paddr", {24'd0, paddr}, 32'h04);
    run_txn(1, 1'b0, 8'h02, 8'h00, 4, 1'b1, 8'h00);
    @(negedge clk);

    // Reset during ACCESS of a req1 write.
    acks_before = n_ack1;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h01; wdata1 = 8'h77;
    @(negedge clk);
    @(negedge clk);
    check("midop_penable", {31'd0, penable}, 32'd1);
    reset = 1'b0;
    req1  = 1'b0;
    #1;
    check("midop_psel",    {31'd0, psel},    32'd0);
    check("midop_penable0",{31'd0, penable}, 32'd0);
    check("midop_busy",    {31'd0, busy},    32'd0);
    repeat (3) @(negedge clk);
    check("midop_no_ack1", n_ack1, acks_before);
    check("midop_no_write", {24'd0, sregs[1]}, 32'd0);
    check("midop_paddr", {24'd0, paddr}, 32'd0);
    reset = 1'b1;

    // Contention: both requesting writes continuously for 4 transfers.
    req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h02; wdata0 = 8'hA0;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h03; wdata1 = 8'hB1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 10) begin
        @(negedge clk);
        cyc = cyc + 1;
        if (ack0 || ack1) got = 1'b1;
      end
      check("cont_latency", cyc, (k == 0) ? 3 : 4);
      check("cont_grant", {31'd0, ack1}, k % 2);
      check("cont_resp_psel", {31'd0, psel}, 32'd0);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("cont_gap_psel", {31'd0, psel}, 32'd0);
    check("cont_both_ack", {31'd0, both_ack}, 32'd0);
    check("cont_reg2", {24'd0, sregs[2]}, 32'hA0);
    check("cont_reg3", {24'd0, sregs[3]}, 32'hB1);
    repeat (2) @(negedge clk);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
